// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and types shared by the FIFO and its write-side arbiter.
//   FIFO_DW     - FIFO word width
//   FIFO_DEPTH  - FIFO storage depth in words
//   arb_state_t - write arbiter grant state (IDLE, BUSY)
package fifo_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Finds the first set request bit starting at rr_ptr and wrapping modulo N_REQ.
//   req    in  N_REQ  request vector
//   rr_ptr in  PW     index holding highest priority this cycle (< N_REQ)
//   any    out 1      at least one request is set
//   pick   out PW     index of the winning request (0 when any=0)
module rr_pick
  import fifo_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic             any,
  output logic [PW-1:0]    pick
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // Scan every position once, beginning at rr_ptr; the first set bit wins.
  // rr_ptr < N_REQ, so a single conditional subtract performs the wrap.
  always_comb begin
    any   = |req;
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      sum = (sum >= (PW+1)'(N_REQ)) ? (sum - (PW+1)'(N_REQ)) : sum;
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among N_REQ
// producers. A grant lasts up to BURST beats, then priority rotates past the
// owner. Beats are suppressed while fifo_full is high.
//   clk        in  1           clock
//   reset      in  1           asynchronous reset, active low
//   req        in  N_REQ       per-requester word pending
//   req_data   in  N_REQ*DW    requester i's word on [i*DW +: DW]
//   ack        out N_REQ       one-hot: word of that requester written this edge
//   fifo_wen   out 1           FIFO write enable
//   fifo_wdata out DW          owner's word
//   fifo_full  in  1           FIFO full flag
//   busy       out 1           registered; grant in progress
//   owner      out PW          registered index of current/last grant holder
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int DW    = FIFO_DW,
  parameter  int BURST = 4,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  output logic                fifo_wen,
  output logic [DW-1:0]       fifo_wdata,
  input  logic                fifo_full,
  output logic                busy,
  output logic [PW-1:0]       owner
);

  localparam int CW = $clog2(BURST + 1);

  arb_state_t    state;
  logic [PW-1:0] rr_ptr;
  logic [CW-1:0] beat_cnt;
  logic          any;
  logic [PW-1:0] pick;
  logic          owner_req;
  logic          beat;
  logic          release_grant;
  logic [PW-1:0] next_ptr;
  logic [DW-1:0] slot [N_REQ];

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (any),
    .pick   (pick)
  );

  // Unpack the flat requester data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      slot[i] = req_data[i*DW +: DW];
    end
  end

  // Beat qualification and release decision for the current grant.
  // A withdrawn request releases with no beat, even if full just dropped.
  always_comb begin
    owner_req = req[owner];
    if (state == BUSY) begin
      beat          = owner_req && !fifo_full;
      release_grant = !owner_req || (beat && (beat_cnt == CW'(BURST - 1)));
    end else begin
      beat          = 1'b0;
      release_grant = 1'b0;
    end
    // Explicit wrap so non-power-of-two N_REQ never points past the last requester.
    next_ptr = (owner == PW'(N_REQ - 1)) ? '0 : (owner + PW'(1));
  end

  // Write-port outputs: only the owner is ever acked, and only on a beat.
  always_comb begin
    ack = '0;
    if (beat) begin
      ack[owner] = 1'b1;
    end else begin
      ack = '0;
    end
    fifo_wen   = beat;
    fifo_wdata = slot[owner];
  end

  // Grant FSM: pick in IDLE, transfer in BUSY, rotate priority on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state    <= BUSY;
            busy     <= 1'b1;
            owner    <= pick;
            beat_cnt <= '0;
          end
        end
        BUSY: begin
          if (release_grant) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter
// (N_REQ=4, DW=8, BURST=4). Includes a small 16-slot pointer FIFO model whose
// full flag reserves one slot, giving 15 usable words.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        fifo_wen;
  logic [7:0]  fifo_wdata;
  logic        fifo_full;
  logic        busy;
  logic [1:0]  owner;

  // stimulus controls
  logic [3:0]  man_req;
  logic [3:0]  prod_req;
  logic        prod_mode;
  logic        force_full;
  logic        use_model;
  logic        pop;
  logic        clr;
  int          quota [4];
  int          sent  [4] = '{0, 0, 0, 0};

  // FIFO model
  logic [7:0]  mem [16];
  logic [3:0]  wptr = 4'd0;
  logic [3:0]  rptr = 4'd0;

  int          cyc = 0;
  int          rel_cyc;
  int          log_src [$];
  int          log_dat [$];
  int          log_cyc [$];
  int          n_chk = 0;
  int          n_err = 0;

  int          src6 [15] = '{3, 3, 3, 3, 0, 0, 0, 0, 3, 3, 3, 3, 0, 0, 0};
  int          dat6 [15] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h00, 8'h01, 8'h02, 8'h03,
                             8'h34, 8'h35, 8'h36, 8'h37, 8'h04, 8'h05, 8'h06};
  int          gap3 [4]  = '{0, 1, 5, 6};

  fifo_wr_arbiter #(.N_REQ(4), .DW(8), .BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    oh_idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) oh_idx = i;
    end
  endfunction

  // Producers: word i is i*16 + number already accepted from requester i.
  always_comb begin
    req_data = 32'd0;
    for (int i = 0; i < 4; i++) begin
      prod_req[i] = (sent[i] < quota[i]);
      req_data[i*8 +: 8] = 8'(i*16 + sent[i]);
    end
    req       = prod_mode ? prod_req : man_req;
    fifo_full = use_model ? ((wptr + 4'd1) == rptr) : force_full;
  end

  // Write log, FIFO model and per-cycle invariants.
  always @(posedge clk) begin
    chk("wen_while_full", {31'd0, fifo_wen & fifo_full}, 32'd0);
    chk("wen_while_idle", {31'd0, fifo_wen & ~busy}, 32'd0);
    chk("ack_vs_wen", {31'd0, |ack}, {31'd0, fifo_wen});
    chk("ack_onehot", {31'd0, $countones(ack) > 1}, 32'd0);
    if (fifo_wen) begin
      log_src.push_back(oh_idx(ack));
      log_dat.push_back(int'(fifo_wdata));
      log_cyc.push_back(cyc);
      sent[oh_idx(ack)] <= sent[oh_idx(ack)] + 1;
      if (use_model) begin
        mem[wptr] <= fifo_wdata;
        wptr      <= wptr + 4'd1;
      end
    end
    if (clr) begin
      for (int i = 0; i < 4; i++) sent[i] <= 0;
    end
    if (pop) rptr <= rptr + 4'd1;
    cyc <= cyc + 1;
  end

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (log_src.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_log", log_src.size(), n);
  endtask

  task automatic clr_tb();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    log_src.delete();
    log_dat.delete();
    log_cyc.delete();
  endtask

  initial begin
    reset      = 1'b0;
    man_req    = 4'b1111;
    prod_mode  = 1'b0;
    quota      = '{0, 0, 0, 0};
    force_full = 1'b0;
    use_model  = 1'b0;
    pop        = 1'b0;
    clr        = 1'b0;

    // 1: reset held with all requests pending
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_wen", fifo_wen, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_wdata", fifo_wdata, 8'h00);
    end
    @(negedge clk);
    reset   = 1'b1;
    rel_cyc = cyc;
    #1 chk("rel_ack", ack, 0);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_owner", owner, 0);
    chk("t1_ack", ack, 4'b0001);

    // 2: fairness, four full bursts then requester 0 again
    wait_log(20, 40);
    man_req = 4'b0000;
    chk("t1_first_write_cyc", log_cyc[0], rel_cyc + 1);
    for (int k = 0; k < 20; k++) begin
      chk("t2_src", log_src[k], (k / 4) % 4);
      chk("t2_dat", log_dat[k], ((k / 4) % 4) * 16 + ((k / 4) == 4 ? 4 + k % 4 : k % 4));
      chk("t2_cyc", log_cyc[k] - log_cyc[0], 5 * (k / 4) + k % 4);
    end
    repeat (2) @(negedge clk);
    chk("t2_count", log_src.size(), 20);
    chk("t2_idle", busy, 0);

    // 3: full stall for three cycles after beat 2 of requester 2
    clr_tb();
    man_req = 4'b0100;
    wait_log(2, 10);
    force_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_ack", ack, 0);
      chk("t3_stall_wen", fifo_wen, 0);
      chk("t3_stall_busy", busy, 1);
      chk("t3_stall_owner", owner, 2);
    end
    force_full = 1'b0;
    wait_log(3, 5);
    chk("t3_busy_after_b3", busy, 1);
    wait_log(4, 5);
    chk("t3_busy_after_b4", busy, 0);
    man_req = 4'b0000;
    repeat (2) @(negedge clk);
    chk("t3_count", log_src.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t3_src", log_src[k], 2);
      chk("t3_dat", log_dat[k], 8'h20 + k);
      chk("t3_cyc", log_cyc[k] - log_cyc[0], gap3[k]);
    end

    // 4: requester 1 withdraws after two beats; 3 and 0 pending
    clr_tb();
    man_req = 4'b0010;
    wait_log(2, 10);
    chk("t4_owner1", owner, 1);
    man_req = 4'b1001;
    #1;
    chk("t4_wd_ack", ack, 0);
    chk("t4_wd_wen", fifo_wen, 0);
    @(negedge clk);
    chk("t4_rel_busy", busy, 0);
    chk("t4_rel_count", log_src.size(), 2);
    @(negedge clk);
    chk("t4_next_busy", busy, 1);
    chk("t4_next_owner", owner, 3);
    chk("t4_next_ack", ack, 4'b1000);
    @(negedge clk);
    chk("t4_count", log_src.size(), 3);
    chk("t4_dat0", log_dat[0], 8'h10);
    chk("t4_dat1", log_dat[1], 8'h11);
    chk("t4_src2", log_src[2], 3);
    chk("t4_dat2", log_dat[2], 8'h30);
    man_req = 4'b0000;
    @(negedge clk);
    chk("t4_end_busy", busy, 0);

    // 5: async reset during beat 2 of a second grant to requester 2
    clr_tb();
    man_req = 4'b0100;
    wait_log(5, 20);
    chk("t5_pre_owner", owner, 2);
    chk("t5_pre_ack", ack, 4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_wen", fifo_wen, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_owner", owner, 0);
    @(negedge clk);
    reset   = 1'b1;
    man_req = 4'b1111;
    #1 chk("t5_rel_ack", ack, 0);
    @(negedge clk);
    chk("t5_regrant_busy", busy, 1);
    chk("t5_regrant_owner", owner, 0);
    chk("t5_regrant_ack", ack, 4'b0001);
    chk("t5_count", log_src.size(), 5);
    chk("t5_dat4", log_dat[4], 8'h24);
    man_req = 4'b0000;
    @(negedge clk);
    chk("t5_end_busy", busy, 0);

    // 6: 10 words each from requesters 0 and 3 into the FIFO model, reader idle
    clr_tb();
    quota     = '{10, 0, 0, 10};
    use_model = 1'b1;
    prod_mode = 1'b1;
    repeat (45) @(negedge clk);
    chk("t6_count", log_src.size(), 15);
    chk("t6_full", fifo_full, 1);
    chk("t6_wen", fifo_wen, 0);
    chk("t6_owner", owner, 0);
    for (int k = 0; k < 15; k++) begin
      chk("t6_src", log_src[k], src6[k]);
      chk("t6_dat", log_dat[k], dat6[k]);
    end
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_pop_count", log_src.size(), 16);
    chk("t6_pop_src", log_src[15], 0);
    chk("t6_pop_dat", log_dat[15], 8'h07);
    chk("t6_pop_full", fifo_full, 1);
    chk("t6_pop_owner", owner, 3);
    chk("t6_mem15", mem[15], 8'h07);
    chk("t6_mem0", mem[0], 8'h30);
    prod_mode = 1'b0;
    man_req   = 4'b0000;
    @(negedge clk);
    chk("t6_end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
